// File: rtl/cpu_param.sv
// Parametrised multi-cycle core: 16-bit instructions, DATA_W-wide datapath,
// eight general registers, N/V/Z/C flags, done/ill completion pulses.
module cpu_param #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              start,
  input  logic [15:0]       instr,
  output logic              waiting,
  output logic              done,
  output logic              ill,
  output logic [DATA_W-1:0] out,
  output logic              N,
  output logic              V,
  output logic              Z,
  output logic              C
);

  // Handshake: in WAIT, load=1 captures instr into IR and start=1 launches IR
  // at the same edge (a simultaneous load+start executes the new word); both
  // are ignored in every other state, and waiting=1 exactly while in WAIT.
  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WRITE,
    S_WRITE_IMM
  } state_t;

  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [2:0] OPC_MOV = 3'b110;

  state_t              state;
  logic [15:0]         ir;
  logic [DATA_W-1:0]   regs [8];
  logic [DATA_W-1:0]   a;
  logic [DATA_W-1:0]   b;

  logic [2:0]          opc;
  logic [1:0]          op;
  logic [2:0]          rn;
  logic [2:0]          rd;
  logic [1:0]          sh;
  logic [2:0]          rm;
  logic [7:0]          imm8;
  logic                legal;
  logic                is_movi;
  logic                is_cmp;
  logic                reads_a;
  logic [DATA_W-1:0]   imm_ext;
  logic [DATA_W-1:0]   rm_val;
  logic [DATA_W-1:0]   sh_val;
  logic [DATA_W-1:0]   alu_res;
  logic [DATA_W:0]     diff;

  assign opc  = ir[15:13];
  assign op   = ir[12:11];
  assign rn   = ir[10:8];
  assign rd   = ir[7:5];
  assign sh   = ir[4:3];
  assign rm   = ir[2:0];
  assign imm8 = ir[7:0];

  assign legal   = (opc == OPC_ALU) ||
                   ((opc == OPC_MOV) && ((op == 2'b00) || (op == 2'b10)));
  assign is_movi = (opc == OPC_MOV) && (op == 2'b10);
  assign is_cmp  = (opc == OPC_ALU) && (op == 2'b01);
  // MOV-register and MVN only use the Rm operand, so they skip GET_A.
  assign reads_a = (opc == OPC_ALU) && (op != 2'b11);
  assign imm_ext = DATA_W'($signed(imm8));

  assign waiting = (state == S_WAIT);

  always_comb begin
    rm_val = regs[rm];
    sh_val = rm_val;
    case (sh)
      2'b01:   sh_val = {rm_val[DATA_W-2:0], 1'b0};
      2'b10:   sh_val = {1'b0, rm_val[DATA_W-1:1]};
      2'b11:   sh_val = {rm_val[DATA_W-1], rm_val[DATA_W-1:1]};
      default: sh_val = rm_val;
    endcase
  end

  always_comb begin
    alu_res = b;
    if (opc == OPC_ALU) begin
      case (op)
        2'b00:   alu_res = a + b;
        2'b10:   alu_res = a & b;
        2'b11:   alu_res = ~b;
        default: alu_res = b;
      endcase
    end
  end

  // Extra top bit is the borrow out; no borrow means Rn >= sh(Rm) unsigned.
  assign diff = {1'b0, a} - {1'b0, b};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_WAIT;
      ir    <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      a     <= '0;
      b     <= '0;
      out   <= '0;
      N     <= 1'b0;
      V     <= 1'b0;
      Z     <= 1'b0;
      C     <= 1'b0;
      done  <= 1'b0;
      ill   <= 1'b0;
    end else begin
      done <= 1'b0;
      ill  <= 1'b0;
      case (state)
        S_WAIT: begin
          if (load)  ir    <= instr;
          if (start) state <= S_DECODE;
        end
        S_DECODE: begin
          if (!legal) begin
            state <= S_WAIT;
            ill   <= 1'b1;
          end else if (is_movi) begin
            state <= S_WRITE_IMM;
          end else if (reads_a) begin
            state <= S_GET_A;
          end else begin
            state <= S_GET_B;
          end
        end
        S_GET_A: begin
          a     <= regs[rn];
          state <= S_GET_B;
        end
        S_GET_B: begin
          b     <= sh_val;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (is_cmp) begin
            Z     <= (diff[DATA_W-1:0] == '0);
            N     <= diff[DATA_W-1];
            V     <= (a[DATA_W-1] ^ b[DATA_W-1]) & (diff[DATA_W-1] ^ a[DATA_W-1]);
            C     <= ~diff[DATA_W];
            state <= S_WAIT;
            done  <= 1'b1;
          end else begin
            out   <= alu_res;
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          regs[rd] <= out;
          state    <= S_WAIT;
          done     <= 1'b1;
        end
        S_WRITE_IMM: begin
          regs[rn] <= imm_ext;
          state    <= S_WAIT;
          done     <= 1'b1;
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule
